// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drains a FIFO onto an asynchronous serial line. Whenever enabled and the
// FIFO is not empty, one N-bit word is popped and sent LSB first as:
//   start bit (0), N data bits, optional even-parity bit, stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles. With enable held high and
// words queued, frames go out back to back with two idle-high cycles (POP,
// LOAD) between the end of one stop bit and the next start bit.
//
// Parameters
//   N            data word width, equal to the FIFO element width
//   CLKS_PER_BIT clk cycles per serial bit (>= 2)
//   PARITY_EN    1 inserts an even-parity bit after the data bits
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   enable      allows new frames to start; only looked at on frame boundaries
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO pop strobe, one cycle per word (registered)
//   tx          serial output, idle high (registered)
//   busy        high from POP through the last STOP cycle (registered)
//   frame_done  one-cycle pulse during the last STOP cycle (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         fifo_empty,
    input  logic [N-1:0] fifo_data,
    output logic         fifo_rd_en,
    output logic         tx,
    output logic         busy,
    output logic         frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(N + 1);

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    // One cycle before the last cycle of a bit; frame_done is registered, so
    // it has to be armed here to land on the final STOP cycle.
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [TW-1:0]   bit_timer;
    logic [BW-1:0]   bit_idx;
    logic [N-1:0]    shift_reg;
    logic            par_bit;
    logic            bit_end;
    logic            can_pop;

    assign bit_end = (bit_timer == T_LAST);
    assign can_pop = enable && !fifo_empty;

    // -------------------------------------------------------------------------
    // Control FSM. All outputs are registered alongside the state so that tx
    // and fifo_rd_en never see a combinational path from the inputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_timer  <= '0;
            bit_idx    <= '0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    tx        <= 1'b1;
                    busy      <= 1'b0;
                    bit_timer <= '0;
                    bit_idx   <= '0;
                    if (can_pop) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                // fifo_data becomes valid during LOAD, one cycle after the pop.
                POP: begin
                    state <= LOAD;
                end

                LOAD: begin
                    state     <= START;
                    tx        <= 1'b0;
                    bit_timer <= '0;
                end

                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        tx        <= shift_reg[0];
                        bit_timer <= '0;
                        bit_idx   <= '0;
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (bit_idx == B_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // shift_reg was already advanced, so [0] is the next bit
                            tx      <= shift_reg[0];
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state     <= STOP;
                        tx        <= 1'b1;
                        bit_timer <= '0;
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        if (can_pop) begin
                            state      <= POP;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_timer <= bit_timer + TW'(1);
                        if (bit_timer == T_PRE) begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    bit_timer  <= '0;
                    bit_idx    <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Data path: word capture and shifting. No reset needed, the FSM never
    // reads these before a LOAD has refreshed them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift_reg <= fifo_data;
            par_bit   <= ^fifo_data;
        end else if (bit_end &&
                     ((state == START) || ((state == DATA) && (bit_idx != B_LAST)))) begin
            shift_reg <= shift_reg >> 1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Directed bench for fifo_uart_tx. Two instances (N=8, CLKS_PER_BIT=4): dut0
// without parity, dut1 with even parity. Each has a small FIFO model whose
// read data appears the cycle after fifo_rd_en. Outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int N   = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en0, en1;
    logic [7:0] fd0 = 8'h00, fd1 = 8'h00;
    logic       empty0, empty1;
    logic       rd0, tx0, busy0, done0;
    logic       rd1, tx1, busy1, done1;

    logic [7:0] mem0 [0:15];
    logic [7:0] mem1 [0:15];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    int underflow = 0;

    int cyc = 0;
    int rd_cnt0 = 0, rd_cnt1 = 0;
    int rd_t0 [0:31];
    int rd_t1 [0:31];

    int n_chk  = 0;
    int n_fail = 0;

    fifo_uart_tx #(.N(N), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en0),
        .fifo_empty (empty0),
        .fifo_data  (fd0),
        .fifo_rd_en (rd0),
        .tx         (tx0),
        .busy       (busy0),
        .frame_done (done0)
    );

    fifo_uart_tx #(.N(N), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en1),
        .fifo_empty (empty1),
        .fifo_data  (fd1),
        .fifo_rd_en (rd1),
        .tx         (tx1),
        .busy       (busy1),
        .frame_done (done1)
    );

    // FIFO models: registered read data, empty flag from pointers
    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd0) begin
            if (wp0 == rp0) underflow <= underflow + 1;
            else begin
                fd0 <= mem0[rp0 % 16];
                rp0 <= rp0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd1) begin
            if (wp1 == rp1) underflow <= underflow + 1;
            else begin
                fd1 <= mem1[rp1 % 16];
                rp1 <= rp1 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rd0 === 1'b1) begin
            rd_t0[rd_cnt0 % 32] <= cyc;
            rd_cnt0 <= rd_cnt0 + 1;
        end
        if (rd1 === 1'b1) begin
            rd_t1[rd_cnt1 % 32] <= cyc;
            rd_cnt1 <= rd_cnt1 + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        if (idx == 0) begin
            mem0[wp0 % 16] = d;
            wp0 = wp0 + 1;
        end else begin
            mem1[wp1 % 16] = d;
            wp1 = wp1 + 1;
        end
    endtask

    function automatic logic tx_of(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction
    function automatic logic busy_of(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done_of(input int idx);
        return (idx == 0) ? done0 : done1;
    endfunction
    function automatic logic rd_of(input int idx);
        return (idx == 0) ? rd0 : rd1;
    endfunction

    // Wait for the start bit, then check every cycle of the frame against
    // the expected bit pattern. drop_bit / abort_bit (frame bit numbers, 0 =
    // start bit) deassert enable or assert reset one cycle into that bit.
    task automatic frame(input int idx, input logic [7:0] d, input logic par_en,
                         input logic par, input int drop_bit, input int abort_bit);
        logic [10:0] bits;
        int nbits;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_of(idx) !== 1'b0 && n < 200);
        chk($sformatf("start_latency_%0h", d), n, 3);
        if (n >= 200) return;

        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (par_en) begin
            bits[9]  = par;
            bits[10] = 1'b1;
            nbits    = 11;
        end else begin
            bits[9] = 1'b1;
            nbits   = 10;
        end

        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b > 0 || c > 0) @(negedge clk);
                chk($sformatf("tx_%0h_bit%0d_cyc%0d", d, b, c), tx_of(idx), bits[b]);
                if (c == 0) chk($sformatf("busy_%0h_bit%0d", d, b), busy_of(idx), 1'b1);
                if (b == drop_bit && c == 1) begin
                    if (idx == 0) en0 = 1'b0; else en1 = 1'b0;
                end
                if (b == abort_bit && c == 1) begin
                    #1 rst = 1'b1;
                    #1;
                    chk("rst_mid_tx",    tx_of(idx),   1'b1);
                    chk("rst_mid_busy",  busy_of(idx), 1'b0);
                    chk("rst_mid_done",  done_of(idx), 1'b0);
                    chk("rst_mid_rd_en", rd_of(idx),   1'b0);
                    return;
                end
                if (b == nbits - 1 && c == CPB - 2)
                    chk($sformatf("done_early_%0h", d), done_of(idx), 1'b0);
                if (b == nbits - 1 && c == CPB - 1)
                    chk($sformatf("done_%0h", d), done_of(idx), 1'b1);
            end
        end
    endtask

    initial begin
        int base;
        int bad;

        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_tx0",   tx0,   1'b1);
        chk("reset_rd0",   rd0,   1'b0);
        chk("reset_busy0", busy0, 1'b0);
        chk("reset_done0", done0, 1'b0);
        chk("reset_tx1",   tx1,   1'b1);
        chk("reset_busy1", busy1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single word 0x01
        push(0, 8'h01);
        en0 = 1'b1;
        frame(0, 8'h01, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        chk("single_busy_after", busy0, 1'b0);
        chk("single_done_after", done0, 1'b0);
        chk("single_tx_after",   tx0,   1'b1);
        chk("single_rd_pulses",  rd_cnt0, 1);

        // Empty FIFO with enable high for 100 cycles
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        chk("empty_fifo_quiet_cycles_bad", bad, 0);
        chk("empty_fifo_rd_pulses", rd_cnt0, 1);
        en0 = 1'b0;

        // Parity frames 0x03 (parity 0) and 0x07 (parity 1), back to back
        push(1, 8'h03);
        push(1, 8'h07);
        en1 = 1'b1;
        frame(1, 8'h03, 1'b1, 1'b0, -1, -1);
        frame(1, 8'h07, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        chk("parity_busy_after", busy1, 1'b0);
        chk("parity_rd_pulses",  rd_cnt1, 2);
        chk("parity_pop_spacing", rd_t1[1] - rd_t1[0], 46);
        en1 = 1'b0;

        // Drain four words
        base = rd_cnt0;
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        push(0, 8'h04);
        en0 = 1'b1;
        frame(0, 8'h01, 1'b0, 1'b0, -1, -1);
        frame(0, 8'h02, 1'b0, 1'b0, -1, -1);
        frame(0, 8'h03, 1'b0, 1'b0, -1, -1);
        frame(0, 8'h04, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        chk("drain_fifo_empty", empty0, 1'b1);
        chk("drain_idle_busy",  busy0,  1'b0);
        chk("drain_idle_tx",    tx0,    1'b1);
        repeat (20) @(negedge clk);
        chk("drain_rd_pulses", rd_cnt0 - base, 4);
        chk("drain_spacing_1", rd_t0[base+1] - rd_t0[base],   42);
        chk("drain_spacing_2", rd_t0[base+2] - rd_t0[base+1], 42);
        chk("drain_spacing_3", rd_t0[base+3] - rd_t0[base+2], 42);
        en0 = 1'b0;

        // Enable dropped during DATA bit 3 of 0x05 with 0x06 still queued
        base = rd_cnt0;
        push(0, 8'h05);
        push(0, 8'h06);
        en0 = 1'b1;
        frame(0, 8'h05, 1'b0, 1'b0, 4, -1);
        @(negedge clk);
        chk("drop_idle_busy", busy0, 1'b0);
        repeat (30) @(negedge clk);
        chk("drop_no_second_pop", rd_cnt0 - base, 1);
        chk("drop_still_idle",    busy0, 1'b0);
        chk("drop_word_queued",   empty0, 1'b0);
        en0 = 1'b1;
        frame(0, 8'h06, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        chk("drop_resume_pops", rd_cnt0 - base, 2);
        en0 = 1'b0;

        // Reset during DATA bit 2 of 0xA5, 0x3C queued behind it
        base = rd_cnt0;
        push(0, 8'hA5);
        push(0, 8'h3C);
        en0 = 1'b1;
        frame(0, 8'hA5, 1'b0, 1'b0, -1, 3);
        @(negedge clk);
        chk("rst_hold_tx",   tx0,   1'b1);
        chk("rst_hold_busy", busy0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        frame(0, 8'h3C, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        chk("rst_recover_pops", rd_cnt0 - base, 2);
        chk("rst_recover_idle", busy0, 1'b0);
        en0 = 1'b0;

        repeat (2) @(negedge clk);
        chk("no_rd_en_while_empty", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
